// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port integer register file with per-register busy scoreboard
// Optional write-first read bypass when REGFILE_BYPASS_EN is defined.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr0_en,
  input  logic [AW-1:0]       wr0_addr,
  input  logic [XLEN-1:0]     wr0_data,
  input  logic                wr1_en,
  input  logic [AW-1:0]       wr1_addr,
  input  logic [XLEN-1:0]     wr1_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  logic wr0_hit;
  logic wr1_hit;

  assign wr0_hit = wr0_en && (wr0_addr != '0);
  assign wr1_hit = wr1_en && (wr1_addr != '0);

  // Port 1 is written last so a load wins a same-register collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (wr0_hit) regs[wr0_addr] <= wr0_data;
      if (wr1_hit) regs[wr1_addr] <= wr1_data;
    end
  end

  // Set is applied after the clears: a new producer stays outstanding.
  always_comb begin
    busy_nxt = busy;
    if (wr0_en) busy_nxt[wr0_addr] = 1'b0;
    if (wr1_en) busy_nxt[wr1_addr] = 1'b0;
    if (iss_en) busy_nxt[iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;

    assign a = rd_addr[k*AW +: AW];

    always_comb begin
      d = regs[a];
`ifdef REGFILE_BYPASS_EN
      if (wr0_hit && (wr0_addr == a)) d = wr0_data;
      if (wr1_hit && (wr1_addr == a)) d = wr1_data;
`else
`endif
      if (!rst_n || (a == '0)) d = '0;
    end

    assign rd_data[k*XLEN +: XLEN] = d;
    assign rd_busy[k] = rst_n & busy[a];
  end

endmodule
